// File: rtl/inv_aes_pkg.sv
// Shared definitions for the inverse-cipher InvMixColumns stage.
// Holds the GF(2^8) constant multipliers used by the column datapath.
// Also holds the sequencer state encoding and the column count.
package inv_aes_pkg;

  localparam int NB_COL = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul09(input logic [7:0] a);
    logic [7:0] x8;
    x8 = gf_xtime(gf_xtime(gf_xtime(a)));
    return x8 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0b(input logic [7:0] a);
    logic [7:0] x2, x8;
    x2 = gf_xtime(a);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0d(input logic [7:0] a);
    logic [7:0] x4, x8;
    x4 = gf_xtime(gf_xtime(a));
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul0e(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(a);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mix_col_word.sv
// InvMixColumns of a single 32-bit column; row 0 sits in bits [31:24].
// Latency: purely combinational, no registers.
// Backpressure: none; the caller decides when the result is captured.
module inv_mix_col_word
  import inv_aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] s0, s1, s2, s3;

  assign s0 = col_in[31:24];
  assign s1 = col_in[23:16];
  assign s2 = col_in[15:8];
  assign s3 = col_in[7:0];

  // Fixed inverse matrix rows {0e,0b,0d,09} rotated per output row.
  always_comb begin
    col_out[31:24] = gf_mul0e(s0) ^ gf_mul0b(s1) ^ gf_mul0d(s2) ^ gf_mul09(s3);
    col_out[23:16] = gf_mul09(s0) ^ gf_mul0e(s1) ^ gf_mul0b(s2) ^ gf_mul0d(s3);
    col_out[15:8]  = gf_mul0d(s0) ^ gf_mul09(s1) ^ gf_mul0e(s2) ^ gf_mul0b(s3);
    col_out[7:0]   = gf_mul0b(s0) ^ gf_mul0d(s1) ^ gf_mul09(s2) ^ gf_mul0e(s3);
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// InvMixColumns over a 128-bit state, one column per cycle through a shared datapath.
// Latency: accept edge E0, columns written on E1..E4, out_valid high after E4.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
// Build option INV_MIXCOL_ADDKEY_EN adds round_key and XORs it in on acceptance.
module inv_mix_columns_seq
  import inv_aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state
`ifdef INV_MIXCOL_ADDKEY_EN
  ,
  input  logic [0:127] round_key
`endif
);

  state_t       state, state_nxt;
  logic [1:0]   col;
  logic [0:127] buffer;
  logic [0:127] load_val;
  logic [31:0]  col_in, col_out;
  logic         accept;
  logic         last_col;

  assign accept   = in_valid & in_ready;
  assign last_col = (col == 2'(NB_COL - 1));

`ifdef INV_MIXCOL_ADDKEY_EN
  assign load_val = in_state ^ round_key;
`else
  assign load_val = in_state;
`endif

  // Column currently being transformed; bit 32*col of buffer is row-0 MSB.
  assign col_in = buffer[{col, 5'b0} +: 32];

  inv_mix_col_word u_col (
    .col_in  (col_in),
    .col_out (col_out)
  );

  // Only expose the buffer once every column has been rewritten.
  assign out_state = out_valid ? buffer : '0;

  // Next-state and handshake outputs; in_ready is held low during reset.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = ~rst;
        if (in_valid && ~rst) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (last_col) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Column counter: cleared on acceptance, stepped once per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst)                   col <= 2'd0;
    else if (accept)           col <= 2'd0;
    else if (state == ST_BUSY) col <= col + 2'd1;
  end

  // State buffer: load on acceptance, then overwrite one column per BUSY cycle.
  always_ff @(posedge clk) begin
    if (rst)                   buffer <= '0;
    else if (accept)           buffer <= load_val;
    else if (state == ST_BUSY) buffer[{col, 5'b0} +: 32] <= col_out;
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Directed bench for inv_mix_columns_seq with hand-computed AES vectors.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Define INV_MIXCOL_ADDKEY_EN to also exercise the round-key path.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;
`ifdef INV_MIXCOL_ADDKEY_EN
  logic [0:127] round_key;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  logic [0:127] v1, e1, v2, e2, zero;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
`ifdef INV_MIXCOL_ADDKEY_EN
    ,
    .round_key (round_key)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one state (block must be in IDLE), wait for the result, check it, and drain it.
  task automatic run(input string tag, input logic [0:127] din, input logic [0:127] exp);
    int cnt;
    in_state = din;
    in_valid = 1'b1;
    #0;
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check({tag, "_busy_in_ready"}, 128'(in_ready), 128'(0));
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, 128'(cnt), 128'(4));
    check({tag, "_out_state"}, out_state, exp);
    check({tag, "_exclusive"}, 128'(in_ready & out_valid), 128'(0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drained"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    int cnt;
    v1   = 128'h8e4da1bc_00000000_00000000_00000000;
    e1   = 128'hdb135345_00000000_00000000_00000000;
    v2   = 128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6;
    e2   = 128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5;
    zero = '0;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_state  = '0;
`ifdef INV_MIXCOL_ADDKEY_EN
    round_key = '0;
`endif

    // Reset values, in_ready low while rst is high.
    tick();
    tick();
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state, zero);
    rst = 1'b0;
    tick();
    check("idle_in_ready", 128'(in_ready), 128'(1));

    // 1: single non-zero column.
    run("t1", v1, e1);

    // 2: full state with fixed-point columns.
    run("t2", v2, e2);

    // 3: backpressure for 10 cycles in DONE.
    in_state = v2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("t3_latency", 128'(cnt), 128'(4));
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_state", out_state, e2);
      check("t3_hold_valid", 128'(out_valid), 128'(1));
      check("t3_hold_in_ready", 128'(in_ready), 128'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_release", 128'(out_valid), 128'(0));
    check("t3_release_in_ready", 128'(in_ready), 128'(1));

    // 4: new data offered during BUSY/DONE is not sampled until back in IDLE.
    in_state = v1;
    in_valid = 1'b1;
    tick();
    in_state = v2;
    out_ready = 1'b1;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("t4_latency", 128'(cnt), 128'(4));
    check("t4_first_result", out_state, e1);
    tick();
    check("t4_back_idle_ready", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
    check("t4_second_accepted", 128'(in_ready), 128'(0));
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    check("t4_second_latency", 128'(cnt), 128'(4));
    check("t4_second_result", out_state, e2);
    tick();
    out_ready = 1'b0;
    check("t4_drained", 128'(out_valid), 128'(0));

    // 5: reset while BUSY at column 2 aborts the operation.
    in_state = v2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_out_valid", 128'(out_valid), 128'(0));
    check("t5_out_state", out_state, zero);
    check("t5_in_ready", 128'(in_ready), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("t5_no_output", 128'(out_valid), 128'(0));
      tick();
    end
    run("t5_after", v1, e1);

`ifdef INV_MIXCOL_ADDKEY_EN
    // 6: key is XORed in on acceptance.
    round_key = v2;
    run("t6_addkey", zero, e2);
    round_key = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
